store_buffer: RTL

- Posted-write buffer between the memory stage and the data-memory port.
- Accepts sw stores from the M stage in one cycle and retires them to memory in order over a valid/ready port, so the pipeline does not stall on slow memory.
- Lets loads see pending stores, either by forwarding or by a stall request to pipeline_control.

---
 rtl/store_buffer_pkg.sv | 26 ++
 rtl/store_buffer_if.sv | 45 ++++
 rtl/store_buffer_match.sv | 36 +++
 rtl/store_buffer.sv | 108 ++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared constants and entry type for the store buffer
//
// Package sb_pkg:
//   SB_DEPTH   number of store entries (power of two, >= 2)
//   SB_ADDR_W  byte address width
//   SB_DATA_W  store data width (one word)
//   SB_PTR_W   head/tail pointer width
//   SB_CNT_W   occupancy counter width (holds 0..SB_DEPTH)
//   SB_WADDR_W word address width (byte address without bits [1:0])
//   sb_entry_t {valid, waddr, data}
package sb_pkg;

    localparam int SB_DEPTH   = 4;
    localparam int SB_ADDR_W  = 32;
    localparam int SB_DATA_W  = 32;
    localparam int SB_PTR_W   = $clog2(SB_DEPTH);
    localparam int SB_CNT_W   = $clog2(SB_DEPTH + 1);
    localparam int SB_WADDR_W = SB_ADDR_W - 2;

    typedef struct packed {
        logic                  valid;
        logic [SB_WADDR_W-1:0] waddr;
        logic [SB_DATA_W-1:0]  data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store, load and memory ports of the store buffer
//
// Signals:
//   st_valid/st_addr/st_data/st_ready             store push from the M stage
//   ld_valid/ld_addr/ld_hit/ld_data/ld_stall      load lookup from the M stage
//   mem_req_valid/addr/data/mem_req_ready         head entry offered to memory
//   empty/count                                   occupancy status
// Modports:
//   slave  - the store buffer's view
//   master - the pipeline/memory side's view
interface store_buffer_if;
    import sb_pkg::*;

    logic                 st_valid;
    logic [SB_ADDR_W-1:0] st_addr;
    logic [SB_DATA_W-1:0] st_data;
    logic                 st_ready;

    logic                 ld_valid;
    logic [SB_ADDR_W-1:0] ld_addr;
    logic                 ld_hit;
    logic [SB_DATA_W-1:0] ld_data;
    logic                 ld_stall;

    logic                 mem_req_valid;
    logic [SB_ADDR_W-1:0] mem_req_addr;
    logic [SB_DATA_W-1:0] mem_req_data;
    logic                 mem_req_ready;

    logic                 empty;
    logic [SB_CNT_W-1:0]  count;

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_req_ready,
        output st_ready, ld_hit, ld_data, ld_stall,
               mem_req_valid, mem_req_addr, mem_req_data, empty, count
    );

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_req_ready,
        input  st_ready, ld_hit, ld_data, ld_stall,
               mem_req_valid, mem_req_addr, mem_req_data, empty, count
    );

endinterface

// File: rtl/store_buffer_match.sv
// rtl/store_buffer_match.sv - youngest-wins address CAM over the store entries
//
// Ports:
//   entries_i   entry array (valid, word address, data)
//   head_i      index of the oldest entry
//   ld_waddr_i  load word address (byte address bits [ADDR_W-1:2])
//   hit_o       some valid entry matches the load address
//   data_o      data of the youngest matching entry, 0 when no hit
module sb_match
    import sb_pkg::*;
(
    input  sb_entry_t [SB_DEPTH-1:0] entries_i,
    input  logic [SB_PTR_W-1:0]      head_i,
    input  logic [SB_WADDR_W-1:0]    ld_waddr_i,
    output logic                     hit_o,
    output logic [SB_DATA_W-1:0]     data_o
);

    logic [SB_PTR_W-1:0] idx;

    // Valid entries are contiguous from head, so walking oldest to youngest
    // and letting each later match overwrite the result gives youngest-wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            idx = head_i + SB_PTR_W'(k);
            if (entries_i[idx].valid && (entries_i[idx].waddr == ld_waddr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write buffer between the M stage and data memory
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   sb     store_buffer_if.slave: store push, load lookup, memory request, status
// Build option:
//   STORE_BUFFER_LOAD_FWD_EN defined   -> matching loads are forwarded (ld_hit/ld_data)
//   STORE_BUFFER_LOAD_FWD_EN undefined -> matching loads only raise ld_stall
module store_buffer
    import sb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave sb
);

    sb_entry_t [SB_DEPTH-1:0] entries_q, entries_d;
    logic [SB_PTR_W-1:0]      head_q, head_d;
    logic [SB_PTR_W-1:0]      tail_q, tail_d;
    logic [SB_CNT_W-1:0]      count_q, count_d;

    logic                 st_ready;
    logic                 req_valid;
    logic                 push;
    logic                 pop;
    logic                 match_hit;
    logic [SB_DATA_W-1:0] match_data;

    // Ready depends on registered occupancy only: a full buffer refuses a
    // store even when the head retires in the same cycle.
    assign st_ready  = (count_q != SB_CNT_W'(SB_DEPTH));
    assign req_valid = (count_q != '0);
    assign push      = sb.st_valid && st_ready;
    assign pop       = req_valid && sb.mem_req_ready;

    assign sb.st_ready      = st_ready;
    assign sb.mem_req_valid = req_valid;
    assign sb.mem_req_addr  = {entries_q[head_q].waddr, 2'b00};
    assign sb.mem_req_data  = entries_q[head_q].data;
    assign sb.empty         = (count_q == '0);
    assign sb.count         = count_q;

    // Push and pop never target the same slot: a pop needs count != 0 and a
    // push needs count != DEPTH, so head == tail excludes one of them.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d = head_q + SB_PTR_W'(1);
        end
        if (push) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].waddr = sb.st_addr[SB_ADDR_W-1:2];
            entries_d[tail_q].data  = sb.st_data;
            tail_d = tail_q + SB_PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + SB_CNT_W'(1);
            2'b01:   count_d = count_q - SB_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Searches registered entries only, so a store pushed this cycle is not
    // seen while the entry retiring this cycle still is.
    sb_match u_match (
        .entries_i  (entries_q),
        .head_i     (head_q),
        .ld_waddr_i (sb.ld_addr[SB_ADDR_W-1:2]),
        .hit_o      (match_hit),
        .data_o     (match_data)
    );

`ifdef STORE_BUFFER_LOAD_FWD_EN
    assign sb.ld_hit   = sb.ld_valid && match_hit;
    assign sb.ld_data  = sb.ld_valid ? match_data : '0;
    assign sb.ld_stall = 1'b0;
`else
    logic unused_fwd_data;
    assign unused_fwd_data = ^match_data;
    assign sb.ld_hit   = 1'b0;
    assign sb.ld_data  = '0;
    assign sb.ld_stall = sb.ld_valid && match_hit;
`endif

    // Byte offsets are irrelevant for word stores and word compares.
    logic unused_byte_offsets;
    assign unused_byte_offsets = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

endmodule
